// File: rtl/mem_access_ctrl.sv
// Memory-side initiator: takes one load/store request at a time, drives the
// data-memory strobes, and hands the result back over a response handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request, no strobes
// WRITE | memoryWrite high for one cycle, memory commits on the next edge
// READ  | memoryRead high, latency counter counting down to capture
// RESP  | resp_valid high, response held until the consumer takes it
module mem_access_ctrl #(
  parameter int WIDTH        = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [7:0]         req_addr,
  input  logic [2*WIDTH-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_rdata,
  output logic               resp_write,
  output logic               memoryWrite,
  output logic               memoryRead,
  output logic [7:0]         memoryAddress,
  output logic [2*WIDTH-1:0] memoryWriteData,
  input  logic [2*WIDTH-1:0] memoryOutData
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t     state, state_nx;
  logic [2:0] lat_cnt;
  logic       accept;
  logic       lat_done;

  assign accept   = req_valid && req_ready;
  assign lat_done = (lat_cnt == 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Strobes decode straight from state so reset drops them without waiting
  // for a clock edge.
  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    memoryWrite = 1'b0;
    memoryRead  = 1'b0;
    resp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (accept) state_nx = req_write ? WRITE : READ;
      end
      WRITE: begin
        memoryWrite = 1'b1;
        state_nx    = RESP;
      end
      READ: begin
        memoryRead = 1'b1;
        if (lat_done) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address and write data are only reloaded on accept, so they stay stable
  // across the strobe window and afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memoryAddress   <= '0;
      memoryWriteData <= '0;
      resp_write      <= 1'b0;
      resp_rdata      <= '0;
      lat_cnt         <= '0;
    end else begin
      if (accept) begin
        memoryAddress <= req_addr;
        resp_write    <= req_write;
        lat_cnt       <= 3'(READ_LATENCY);
        if (req_write) memoryWriteData <= req_wdata;
      end
      if (state == WRITE) resp_rdata <= '0;
      if (state == READ) begin
        lat_cnt <= lat_cnt - 3'd1;
        if (lat_done) resp_rdata <= memoryOutData;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (read latency 1 and 3), each with a
// behavioural memory and a transaction-level reference model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_write, resp_valid, resp_ready, resp_write, mw, mr;
  logic [1:0][7:0]  req_addr, maddr_o;
  logic [1:0][15:0] req_wdata, resp_rdata, mwdata_o;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // cycles from accept until the response is presented
  function automatic int dly(int i, bit wr);
    return wr ? 1 : lat(i);
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] mem [256];
    logic [2:0]  rd_cnt;
    logic [15:0] odata;

    mem_access_ctrl #(.WIDTH(8), .READ_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]), .resp_write(resp_write[g]),
      .memoryWrite(mw[g]), .memoryRead(mr[g]), .memoryAddress(maddr_o[g]),
      .memoryWriteData(mwdata_o[g]), .memoryOutData(odata)
    );

    // Memory: data valid once the read enable has been high for latency-1 edges,
    // so it is sampled on the latency-th edge; junk before that.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_cnt <= 3'd0;
        for (int a = 0; a < 256; a++) mem[a] <= 16'h0000;
      end else begin
        if (mw[g]) mem[maddr_o[g]] <= mwdata_o[g];
        rd_cnt <= mr[g] ? 3'(rd_cnt + 3'd1) : 3'd0;
      end
    end

    always_comb odata = (mr[g] && int'(rd_cnt) >= lat(g) - 1) ? mem[maddr_o[g]] : 16'hDEAD;

    assert property (@(posedge clk) disable iff (reset) !(mw[g] && mr[g]));
  end

  // Reference model: one outstanding transaction, k = edges since its accept.
  bit          act [2];
  bit          mwr [2];
  int          k   [2];
  logic [7:0]  m_addr [2];
  logic [15:0] m_wd [2];
  logic [15:0] m_rd [2];
  logic [15:0] shadow [2][256];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 1'b0;
        k[i]   = 0;
        for (int a = 0; a < 256; a++) shadow[i][a] = 16'h0000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (act[i]) begin
          if (k[i] >= dly(i, mwr[i]) && resp_ready[i]) act[i] = 1'b0;
          else k[i]++;
        end else if (req_valid[i]) begin
          act[i]    = 1'b1;
          k[i]      = 0;
          mwr[i]    = req_write[i];
          m_addr[i] = req_addr[i];
          if (req_write[i]) begin
            m_wd[i] = req_wdata[i];
            shadow[i][req_addr[i]] = req_wdata[i];
          end else begin
            m_rd[i] = shadow[i][req_addr[i]];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        bit exp_rv;
        exp_rv = act[i] && k[i] >= dly(i, mwr[i]);
        chk("req_ready", i, 32'(req_ready[i]), 32'(!act[i]));
        chk("memoryWrite", i, 32'(mw[i]), 32'(act[i] && mwr[i] && k[i] == 0));
        chk("memoryRead", i, 32'(mr[i]), 32'(act[i] && !mwr[i] && k[i] < lat(i)));
        chk("resp_valid", i, 32'(resp_valid[i]), 32'(exp_rv));
        chk("strobe_excl", i, 32'(mw[i] && mr[i]), 32'(0));
        if (act[i]) chk("memoryAddress", i, 32'(maddr_o[i]), 32'(m_addr[i]));
        if (act[i] && mwr[i] && k[i] == 0) chk("memoryWriteData", i, 32'(mwdata_o[i]), 32'(m_wd[i]));
        if (exp_rv) begin
          chk("resp_write", i, 32'(resp_write[i]), 32'(mwr[i]));
          chk("resp_rdata", i, 32'(resp_rdata[i]), mwr[i] ? 32'(0) : 32'(m_rd[i]));
        end
      end
    end
  end

  // One transaction; hold>0 keeps resp_ready low for hold cycles while an
  // illegal request is presented.
  task automatic do_req(int i, bit wr, logic [7:0] a, logic [15:0] d, int hold,
                        output int cyc, output logic [15:0] rd, output logic rw,
                        output logic s_mw, output logic s_mr,
                        output logic [7:0] s_addr, output logic [15:0] s_wd);
    int guard;
    guard = 0;
    resp_ready[i] = (hold == 0);
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d;
    while (!req_ready[i] && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk("accept_timeout", i, 32'(1), 32'(0));
    @(negedge clk);
    req_valid[i] = 1'b0;
    s_mw = mw[i]; s_mr = mr[i]; s_addr = maddr_o[i]; s_wd = mwdata_o[i];
    cyc = 1;
    while (!resp_valid[i] && cyc < 50) begin @(negedge clk); cyc++; end
    rd = resp_rdata[i];
    rw = resp_write[i];
    if (hold > 0) begin
      req_valid[i] = 1'b1; req_write[i] = 1'b1; req_addr[i] = 8'h33; req_wdata[i] = 16'h0BAD;
      repeat (hold) begin
        chk("bp_req_ready", i, 32'(req_ready[i]), 32'(0));
        chk("bp_resp_valid", i, 32'(resp_valid[i]), 32'(1));
        chk("bp_resp_rdata", i, 32'(resp_rdata[i]), 32'(rd));
        @(negedge clk);
      end
      req_valid[i] = 1'b0;
      resp_ready[i] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic seq_lat1();
    int cyc; logic [15:0] rd, wd; logic rw, smw, smr; logic [7:0] sa;
    int acc[$];
    int n;
    do_req(0, 1'b1, 8'h05, 16'hBEEF, 0, cyc, rd, rw, smw, smr, sa, wd);
    chk("st_strobe", 0, 32'(smw), 32'(1));
    chk("st_addr", 0, 32'(sa), 32'h05);
    chk("st_wdata", 0, 32'(wd), 32'hBEEF);
    chk("st_rdata", 0, 32'(rd), 32'(0));
    chk("st_rwrite", 0, 32'(rw), 32'(1));
    do_req(0, 1'b0, 8'h05, 16'h0000, 0, cyc, rd, rw, smw, smr, sa, wd);
    chk("ld_rdata", 0, 32'(rd), 32'hBEEF);
    chk("ld_latency", 0, 32'(cyc), 32'(2));
    chk("ld_rwrite", 0, 32'(rw), 32'(0));
    do_req(0, 1'b1, 8'h40, 16'hA5A5, 0, cyc, rd, rw, smw, smr, sa, wd);
    do_req(0, 1'b0, 8'h40, 16'h0000, 5, cyc, rd, rw, smw, smr, sa, wd);
    chk("bp_rdata", 0, 32'(rd), 32'hA5A5);
    // back-to-back stores
    resp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 8'h10; req_wdata[0] = 16'h1000;
    for (n = 0; n < 15; n++) begin
      chk("b2b_noread", 0, 32'(mr[0]), 32'(0));
      if (req_ready[0]) acc.push_back(n);
      @(negedge clk);
      req_addr[0] = 8'(8'h10 + n); req_wdata[0] = 16'(16'h1000 + n);
    end
    req_valid[0] = 1'b0;
    chk("b2b_count", 0, 32'(acc.size()), 32'(5));
    for (int j = 1; j < acc.size(); j++) chk("b2b_interval", 0, 32'(acc[j] - acc[j-1]), 32'(3));
    repeat (4) @(negedge clk);
  endtask

  task automatic seq_lat3();
    int cyc; logic [15:0] rd, wd; logic rw, smw, smr; logic [7:0] sa;
    do_req(1, 1'b1, 8'h7F, 16'h1111, 0, cyc, rd, rw, smw, smr, sa, wd);
    do_req(1, 1'b1, 8'h80, 16'h2222, 0, cyc, rd, rw, smw, smr, sa, wd);
    do_req(1, 1'b0, 8'h7F, 16'h0000, 0, cyc, rd, rw, smw, smr, sa, wd);
    chk("bank_lo", 1, 32'(rd), 32'h1111);
    chk("l3_latency", 1, 32'(cyc), 32'(4));
    chk("l3_read_strobe", 1, 32'(smr), 32'(1));
    do_req(1, 1'b0, 8'h80, 16'h0000, 0, cyc, rd, rw, smw, smr, sa, wd);
    chk("bank_hi", 1, 32'(rd), 32'h2222);
  endtask

  task automatic rnd(int i);
    repeat (400) begin
      @(negedge clk);
      req_valid[i]  = ($urandom_range(0, 1) == 1);
      req_write[i]  = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 4))
        0: req_addr[i] = 8'h05;
        1: req_addr[i] = 8'h7F;
        2: req_addr[i] = 8'h80;
        3: req_addr[i] = 8'hFF;
        default: req_addr[i] = 8'($urandom_range(0, 255));
      endcase
      req_wdata[i]  = 16'($urandom);
      resp_ready[i] = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    req_valid[i] = 1'b0; resp_ready[i] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    req_valid = '0; req_write = '0; resp_ready = '1;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", i, 32'(req_ready[i]), 32'(0));
      chk("rst_strobes", i, 32'({mw[i], mr[i], resp_valid[i], resp_write[i]}), 32'(0));
      chk("rst_addr_data", i, {8'(maddr_o[i]), 16'(mwdata_o[i]) | resp_rdata[i]}, 32'(0));
    end
    #1 reset = 1'b0;
    @(negedge clk);

    fork
      seq_lat1();
      seq_lat3();
    join

    // abort a load mid-flight
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h05;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("rst_pre_read", 0, 32'(mr[0]), 32'(1));
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_read", 0, 32'(mr[0]), 32'(0));
    chk("rst_mid_ready", 0, 32'(req_ready[0]), 32'(0));
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_post_ready", 0, 32'(req_ready[0]), 32'(1));
    chk("rst_post_read", 0, 32'(mr[0]), 32'(0));
    @(negedge clk);

    fork
      rnd(0);
      rnd(1);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the 256-word data memory. It accepts single load/store requests from the datapath over a valid/ready handshake. It then sequences the memory control strobes (memoryWrite, memoryRead, memoryAddress, memoryWriteData) and returns a response over a second valid/ready handshake.
- It is the master end of the memory interface and sits between the CPU control unit/datapath and the memory block.

Parameters:
- WIDTH, 8: datapath width; memory word is 2*WIDTH bits.
- READ_LATENCY, 1: clock edges from memoryRead assertion to valid memoryOutData; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  8  word address; bit 7 selects the upper SRAM bank.
- req_wdata  input  2*WIDTH  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  2*WIDTH  load data; 0 for store responses.
- resp_write  output  1  echoes req_write of the completed request.
- memoryWrite  output  1  memory write strobe.
- memoryRead  output  1  memory read enable.
- memoryAddress  output  8  memory address.
- memoryWriteData  output  2*WIDTH  memory write data.
- memoryOutData  input  2*WIDTH  memory read data.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0: memoryWrite, memoryRead, memoryAddress, memoryWriteData, resp_valid, resp_rdata, resp_write.
  - The latency counter is cleared.
  - req_ready is 0 while reset is high.
  - Reset asserted mid-transaction aborts it immediately; no strobe survives reset.
- States:
  - IDLE: req_ready=1, no strobes.
  - WRITE: memoryWrite=1 for exactly one cycle.
  - READ: memoryRead=1, latency counter running.
  - RESP: resp_valid=1, strobes low.
- Accept: a request is accepted on an edge where req_valid and req_ready are both 1. On that edge the controller registers req_addr into memoryAddress, req_wdata into memoryWriteData (store only), and req_write into resp_write.
- Store path:
  - IDLE goes to WRITE. memoryWrite is high for the single cycle after acceptance.
  - On the next edge, memory commits the write and the state goes to RESP with resp_rdata=0.
- Load path:
  - IDLE goes to READ. memoryRead stays high and the counter loads READ_LATENCY.
  - The counter decrements each edge. On the edge where it equals 1, memoryOutData is captured into resp_rdata and the state goes to RESP.
  - With READ_LATENCY=1, resp_valid is high 2 cycles after acceptance.
- RESP:
  - resp_valid, resp_rdata and resp_write are held stable until resp_valid and resp_ready are both high on an edge. The state then returns to IDLE.
  - req_ready stays 0 in RESP; there is no overlap of requests.
- Invariants:
  - memoryWrite and memoryRead are never high in the same cycle.
  - memoryAddress and memoryWriteData are stable for the whole time either strobe is high, and are held until the next accept.
  - req_ready is 1 only in IDLE while reset is low.
- Boundary conditions:
  - Address 8'h7F and 8'h80 both work; bank switching needs no special handling.
  - Back-to-back requests: the next accept can occur in the cycle after a RESP handshake, so throughput is 1 transaction per 3 cycles for stores with resp_ready held 1.
  - req_valid deasserted before acceptance has no effect.
  - Request inputs are ignored outside IDLE.

Test Plan:
- Reset mid-load: assert reset while in READ -> memoryRead=0 in the same cycle; after release, req_ready=1 and state is IDLE.
- Store then load, WIDTH=8: store addr 8'h05, data 16'hBEEF -> memoryWrite high for exactly 1 cycle with memoryAddress=8'h05 and memoryWriteData=16'hBEEF; resp_valid with resp_write=1 and resp_rdata=0. Then load 8'h05 -> resp_rdata=16'hBEEF, resp_valid 2 cycles after acceptance.
- Bank boundary: store 16'h1111 at 8'h7F and 16'h2222 at 8'h80, then load both -> 16'h1111 and 16'h2222 respectively.
- Response backpressure: hold resp_ready=0 for 5 cycles after a load of 16'hA5A5 -> resp_valid and resp_rdata are held; req_ready=0; a req_valid presented during the wait is not accepted.
- READ_LATENCY=3 instance: load -> memoryRead high for 3 cycles; capture on the 3rd edge; resp_valid 4 cycles after acceptance.
- Back-to-back stores with req_valid and resp_ready held 1 -> accepts every 3 cycles; memoryRead never asserted; strobes are never simultaneous (assertion over the whole run).
